// File: rtl/type_pkg.sv
// Shared types for the load/store unit and its RAM port.
// RAM_WORDS sets the RAM depth; RAMAddrBus is sized to index exactly that many words.
package type_pkg;

    localparam int unsigned RAM_WORDS = 256;
    localparam int          RAM_AW    = $clog2(RAM_WORDS);

    typedef logic [31:0]       RAMBus;
    typedef logic [RAM_AW-1:0] RAMAddrBus;

    // Access width as encoded on req_size_i; SZ_BAD is always rejected.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_lane.sv
// Little-endian lane logic for the LSU.
// o_load extracts the addressed byte or half from a RAM word and extends it.
// o_merge splices store data into the addressed lane(s) of a RAM word.
module mem_lsu_lane
    import type_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    lsu_size_e   w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_size = lsu_size_e'(i_size);

    // Pick the addressed byte/half and sign- or zero-extend it to 32 bits.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_load = '0;
        case (w_size)
            SZ_BYTE: o_load = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_load = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            SZ_WORD: o_load = i_word;
            default: o_load = '0;
        endcase
    end

    // Replace only the addressed lane(s) of the old word; a full word store takes i_wdata whole.
    always_comb begin
        o_merge = i_word;
        case (w_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'd0: o_merge = {i_word[31:8], i_wdata[7:0]};
                    2'd1: o_merge = {i_word[31:16], i_wdata[7:0], i_word[7:0]};
                    2'd2: o_merge = {i_word[31:24], i_wdata[7:0], i_word[15:0]};
                    2'd3: o_merge = {i_wdata[7:0], i_word[23:0]};
                    default: o_merge = i_word;
                endcase
            end
            SZ_HALF: o_merge = i_lane[1] ? {i_wdata[15:0], i_word[15:0]}
                                         : {i_word[31:16], i_wdata[15:0]};
            SZ_WORD: o_merge = i_wdata;
            default: o_merge = i_word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit in front of a word-wide RAM with
// combinational read data. Loads take READ, word stores take WRITE, and
// sub-word stores do a read-modify-write through READ then WRITE. Every
// request, including rejected ones, ends in RESP until the core consumes it.
module mem_lsu
    import type_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output RAMAddrBus   ram_waddr_o,
    output RAMBus       ram_wdata_o,
    output logic        ram_we_o,
    output RAMAddrBus   ram_raddr_o,
    input  RAMBus       ram_rdata_i
);

    lsu_state_e  r_state;
    RAMAddrBus   r_widx;
    logic [1:0]  r_lane;
    lsu_size_e   r_size;
    logic        r_we;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    RAMBus       r_wword;
    logic        r_rspValid;
    logic        r_rspErr;
    logic [31:0] r_rspRdata;

    lsu_size_e   w_reqSize;
    logic [31:0] w_offset;
    logic [31:0] w_widxFull;
    logic        w_sizeBad;
    logic        w_misaligned;
    logic        w_outOfRange;
    logic        w_reqErr;
    logic [31:0] w_loadData;
    logic [31:0] w_mergeWord;

    assign w_reqSize    = lsu_size_e'(req_size_i);
    // Addresses below BASE_ADDR wrap to a huge offset and so fail the range check too.
    assign w_offset     = req_addr_i - BASE_ADDR;
    assign w_widxFull   = w_offset >> 2;
    assign w_sizeBad    = (w_reqSize == SZ_BAD);
    assign w_misaligned = ((w_reqSize == SZ_HALF) && req_addr_i[0]) ||
                          ((w_reqSize == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
    assign w_outOfRange = (w_widxFull >= RAM_WORDS);
    assign w_reqErr     = w_sizeBad || w_misaligned || w_outOfRange;

    mem_lsu_lane u_lane (
        .i_word     (ram_rdata_i),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_loadData),
        .o_merge    (w_mergeWord)
    );

    // Request/transaction sequencing: capture on accept, access RAM, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_widx     <= '0;
            r_lane     <= '0;
            r_size     <= SZ_BYTE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_wword    <= '0;
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_widx     <= w_widxFull[RAM_AW-1:0];
                        r_lane     <= req_addr_i[1:0];
                        r_size     <= w_reqSize;
                        r_we       <= req_we_i;
                        r_unsigned <= req_unsigned_i;
                        r_wdata    <= req_wdata_i;
                        if (w_reqErr) begin
                            r_rspValid <= 1'b1;
                            r_rspErr   <= 1'b1;
                            r_rspRdata <= '0;
                            r_state    <= ST_RESP;
                        end else if (req_we_i && (w_reqSize == SZ_WORD)) begin
                            r_wword <= req_wdata_i;
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_we) begin
                        r_wword <= w_mergeWord;
                        r_state <= ST_WRITE;
                    end else begin
                        r_rspValid <= 1'b1;
                        r_rspErr   <= 1'b0;
                        r_rspRdata <= w_loadData;
                        r_state    <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    r_rspValid <= 1'b1;
                    r_rspErr   <= 1'b0;
                    r_rspRdata <= '0;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rspValid <= 1'b0;
                        r_rspErr   <= 1'b0;
                        r_rspRdata <= '0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = r_rspValid;
    assign rsp_err_o   = r_rspErr;
    assign rsp_rdata_o = r_rspRdata;

    // The write strobe is masked by rst so a reset landing in WRITE never commits.
    assign ram_we_o    = (r_state == ST_WRITE) && !rst;
    assign ram_waddr_o = r_widx;
    assign ram_raddr_o = r_widx;
    assign ram_wdata_o = r_wword;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a bench-owned RAM, a shift/mask reference model of the
// memory semantics, a per-cycle compare process and directed vectors.
module tb_mem_lsu;
    import type_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    RAMAddrBus   ram_waddr_o;
    RAMBus       ram_wdata_o;
    logic        ram_we_o;
    RAMAddrBus   ram_raddr_o;
    RAMBus       ram_rdata_i;

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] mdl [RAM_WORDS];

    int          vectors = 0;
    int          miscompares = 0;

    logic        checkEn = 1'b0;
    logic        active = 1'b0;
    int          cyc = 0;
    logic        expErr = 1'b0;
    logic        expStore = 1'b0;
    int          expLat = 0;
    int          expIdx = 0;
    logic [31:0] expRdata = '0;
    logic [31:0] expNewWord = '0;

    mem_lsu #(.BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .ram_waddr_o    (ram_waddr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_we_o       (ram_we_o),
        .ram_raddr_o    (ram_raddr_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-owned RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (ram_we_o) ram[ram_waddr_o] <= ram_wdata_o;
    end
    assign ram_rdata_i = ram[ram_raddr_o];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics: byte offset -> word index and lane, shift/mask extraction and splicing.
    function automatic void modelTxn(input logic we, input logic [1:0] size, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic err, output int lat, output logic [31:0] rdata,
                                     output logic [31:0] newWord, output int idx);
        logic [31:0] off;
        logic [31:0] old;
        logic [31:0] mask;
        logic [31:0] val;
        int nb;
        int sh;
        off = addr - BASE;
        idx = int'(off / 4);
        sh  = 8 * int'(addr[1:0]);
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % nb) != 0) || ((off / 4) >= RAM_WORDS);
        rdata = '0;
        newWord = '0;
        lat = 1;
        if (!err) begin
            old  = mdl[idx];
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            if (!we) begin
                lat = 2;
                val = (old >> sh) & mask;
                if (!uns && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
                rdata = val;
                newWord = old;
            end else begin
                lat = (nb == 4) ? 2 : 3;
                newWord = (old & ~(mask << sh)) | ((wdata << sh) & (mask << sh));
            end
        end
    endfunction

    // Every falling edge: compare handshake, response and RAM-write outputs against the model's timeline.
    always @(negedge clk) begin
        if (checkEn) begin
            logic expValid;
            logic expWe;
            if (active) cyc++;
            expValid = active && (cyc >= expLat);
            expWe    = active && expStore && (cyc == expLat - 1);
            checkOutput("req_ready", 32'(req_ready_o), 32'(!active));
            checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(expValid));
            checkOutput("ram_we", 32'(ram_we_o), 32'(expWe));
            if (expValid) begin
                checkOutput("rsp_rdata", rsp_rdata_o, expRdata);
                checkOutput("rsp_err", 32'(rsp_err_o), 32'(expErr));
            end
            if (expWe) begin
                checkOutput("ram_waddr", 32'(ram_waddr_o), 32'(expIdx));
                checkOutput("ram_wdata", ram_wdata_o, expNewWord);
            end
        end
    end

    // One request/response; literal arguments pin latency, data and error independently of the model.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int rspDelay, input logic useLit,
                                 input int litLat, input logic [31:0] litData, input logic litErr);
        logic e;
        int l;
        logic [31:0] rd;
        logic [31:0] nw;
        int ix;
        int seen;
        modelTxn(we, size, uns, addr, wdata, e, l, rd, nw, ix);
        expErr = e; expLat = l; expRdata = rd; expNewWord = nw; expIdx = ix;
        expStore = we && !e;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
        req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        active = 1'b1;
        cyc = 0;
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                seen = i;
                break;
            end
        end
        if (seen == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rsp_timeout: got no response, want one within 8 cycles of addr %h", addr);
            checkEn = 1'b0;
            active = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            checkEn = 1'b1;
            return;
        end
        if (useLit) begin
            checkOutput("lit_latency", 32'(seen), 32'(litLat));
            checkOutput("lit_rdata", rsp_rdata_o, litData);
            checkOutput("lit_err", 32'(rsp_err_o), 32'(litErr));
        end
        repeat (rspDelay) @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        active = 1'b0;
        if (expStore) mdl[ix] = nw;
        if (!e) checkOutput("ram_word", ram[ix], mdl[ix]);
    endtask

    // Sub-word store with reset asserted during its WRITE cycle: nothing may be written or answered.
    task automatic resetInWrite(input logic [31:0] addr, input logic [31:0] wdata);
        int ix;
        ix = int'((addr - BASE) / 4);
        checkEn = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = addr; req_wdata_i = wdata;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("we_gated_by_rst", 32'(ram_we_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_ready", 32'(req_ready_o), 32'd1);
        checkOutput("rst_mid_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_mid_rdata", rsp_rdata_o, 32'd0);
        checkOutput("rst_mid_err", 32'(rsp_err_o), 32'd0);
        checkOutput("rst_mid_we", 32'(ram_we_o), 32'd0);
        checkOutput("rst_mid_ram", ram[ix], mdl[ix]);
        checkEn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < int'(RAM_WORDS); i++) begin
            ram[i] = '0;
            mdl[i] = '0;
        end
        rst = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready_o), 32'd1);
        checkOutput("reset_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset_rdata", rsp_rdata_o, 32'd0);
        checkOutput("reset_err", 32'(rsp_err_o), 32'd0);
        checkOutput("reset_we", 32'(ram_we_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        checkEn = 1'b1;

        // we, size, uns, addr, wdata, delay, useLit, lat, rdata, err
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h8,   32'hDEAD_BEEF, 0, 1'b1, 2, 32'h0000_0000, 1'b0);
        checkOutput("lit_word2_sw", ram[2], 32'hDEAD_BEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8,   32'h0,         0, 1'b1, 2, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h9,   32'h0000_0080, 0, 1'b1, 3, 32'h0000_0000, 1'b0);
        checkOutput("lit_word2_sb", ram[2], 32'hDEAD_80EF);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h9,   32'h0,         0, 1'b1, 2, 32'hFFFF_FF80, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h9,   32'h0,         0, 1'b1, 2, 32'h0000_0080, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h3,   32'h1234,      0, 1'b1, 1, 32'h0000_0000, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, BASE + 32'(4 * RAM_WORDS), 32'h0, 0, 1'b1, 1, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8,   32'h0,         5, 1'b1, 2, 32'hDEAD_80EF, 1'b0);

        // Model-driven vectors: halves, upper lanes, illegal size, last word, misaligned word.
        applyStimulus(1'b1, 2'b01, 1'b0, 32'hA,   32'h5555_BEEF, 0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'hA,   32'h0,         0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'hA,   32'h0,         1, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'hB,   32'h0000_007F, 0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'hB,   32'h0,         0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h10,  32'h0000_8001, 0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h10,  32'h0,         0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10,  32'h0,         0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA5A5_0F0F, 0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h3FD, 32'h0,         0, 1'b0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h6,   32'h1111_1111, 0, 1'b0, 0, 32'h0, 1'b0);

        resetInWrite(32'h8, 32'h0000_0055);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8,   32'h0,         0, 1'b0, 0, 32'h0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, want finish before 200000");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] timeout");
    end

endmodule
